// File: rtl/dac_waveform_player.sv
// rtl/dac_waveform_player.sv - triggered waveform RAM playback into a serial offset-binary DAC
module dac_waveform_player #(
    parameter int DATA_W        = 14,
    parameter int ADDR_W        = 12,
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 80
) (
    input  logic              ipDspClk,
    input  logic              Reset,
    input  logic              ipEnable,
    input  logic [ADDR_W-1:0] ipLength,
    input  logic              ipTrigger,
    output logic [ADDR_W-1:0] opAddress,
    input  logic [DATA_W-1:0] ipReadData,
    output logic              opSClk,
    output logic              opnCS,
    output logic              opData,
    output logic              opBusy,
    output logic              opDone,
    output logic [7:0]        opMissedCount
);
    localparam int WORD_W = 16;
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int TMR_W  = $clog2(SAMPLE_PERIOD + 1);

    if (CLK_DIV < 1) begin : gDivCheck
        $error("CLK_DIV must be at least 1");
    end
    if (SAMPLE_PERIOD < 32 * CLK_DIV + 4) begin : gPeriodCheck
        $error("SAMPLE_PERIOD too short for a full DAC frame");
    end
    if (DATA_W >= WORD_W) begin : gWidthCheck
        $error("DATA_W must be narrower than the 16-bit DAC word");
    end

    typedef enum logic [2:0] {sIdle, sFetch, sLatch, sShift, sWait} tState;

    tState              state;
    tState              stateNext;
    logic [ADDR_W-1:0]  length;
    logic [WORD_W-1:0]  shiftReg;
    logic [WORD_W-1:0]  sampleWord;
    logic [DIV_W-1:0]   halfCnt;
    logic [4:0]         halfIdx;
    logic [TMR_W-1:0]   timer;
    logic               accept;
    logic               halfEnd;
    logic               frameEnd;
    logic               burstEnd;
    logic               periodEnd;

    // Two's complement to offset binary: flip the sign bit, left-justify in 16 bits
    assign sampleWord = {~ipReadData[DATA_W-1], ipReadData[DATA_W-2:0], {(WORD_W-DATA_W){1'b0}}};
    assign accept     = ipTrigger && ipEnable && (ipLength != '0) && !opBusy;
    assign halfEnd    = (halfCnt == DIV_W'(CLK_DIV - 1));
    assign frameEnd   = halfEnd && (halfIdx == 5'd31);
    assign burstEnd   = (opAddress == length - ADDR_W'(1)) || !ipEnable;
    assign periodEnd  = (timer == TMR_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge ipDspClk) begin
        if (Reset) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            sIdle:   if (accept) stateNext = sFetch;
            sFetch:  stateNext = sLatch;
            sLatch:  stateNext = sShift;
            sShift:  if (frameEnd) stateNext = sWait;
            sWait: begin
                if (burstEnd) begin
                    stateNext = sIdle;
                end else if (periodEnd) begin
                    stateNext = sFetch;
                end
            end
            default: stateNext = sIdle;
        endcase
    end

    always_ff @(posedge ipDspClk) begin
        if (Reset) begin
            opAddress     <= '0;
            length        <= '0;
            shiftReg      <= '0;
            halfCnt       <= '0;
            halfIdx       <= '0;
            timer         <= '0;
            opSClk        <= 1'b1;
            opnCS         <= 1'b1;
            opData        <= 1'b0;
            opBusy        <= 1'b0;
            opDone        <= 1'b0;
            opMissedCount <= '0;
        end else begin
            opDone <= 1'b0;
            if (ipTrigger && opBusy && (opMissedCount != 8'hFF)) begin
                opMissedCount <= opMissedCount + 8'd1;
            end
            // Frame-start timer: zero during Fetch, free-running until the next Fetch
            timer <= (stateNext == sFetch) ? '0 : timer + TMR_W'(1);
            case (state)
                sIdle: begin
                    if (opDone) begin
                        opBusy <= 1'b0;
                    end
                    if (accept) begin
                        length    <= ipLength;
                        opAddress <= '0;
                        opBusy    <= 1'b1;
                    end
                end
                sLatch: begin
                    shiftReg <= sampleWord;
                    opnCS    <= 1'b0;
                    opSClk   <= 1'b1;
                    opData   <= sampleWord[WORD_W-1];
                    halfCnt  <= '0;
                    halfIdx  <= '0;
                end
                sShift: begin
                    if (!halfEnd) begin
                        halfCnt <= halfCnt + DIV_W'(1);
                    end else begin
                        halfCnt <= '0;
                        halfIdx <= halfIdx + 5'd1;
                        if (halfIdx == 5'd31) begin
                            opSClk <= 1'b1;
                            opnCS  <= 1'b1;
                            opData <= 1'b0;
                        end else if (!halfIdx[0]) begin
                            opSClk <= 1'b0;
                        end else begin
                            // Data moves only on SClk rising so it is stable at the DAC's falling-edge sample
                            opSClk   <= 1'b1;
                            opData   <= shiftReg[WORD_W-2];
                            shiftReg <= {shiftReg[WORD_W-2:0], 1'b0};
                        end
                    end
                end
                sWait: begin
                    if (burstEnd) begin
                        opDone <= 1'b1;
                    end else if (periodEnd) begin
                        opAddress <= opAddress + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_waveform_player.sv
// tb/tb_dac_waveform_player.sv - randomized self-checking bench for dac_waveform_player
module tb_dac_waveform_player;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;
    localparam int CD     = 2;
    localparam int SP     = 80;

    logic              ipDspClk = 1'b0;
    logic              Reset;
    logic              ipEnable;
    logic              ipTrigger;
    logic [ADDR_W-1:0] ipLength;
    logic [ADDR_W-1:0] opAddress;
    logic [DATA_W-1:0] ipReadData;
    logic              opSClk;
    logic              opnCS;
    logic              opData;
    logic              opBusy;
    logic              opDone;
    logic [7:0]        opMissedCount;

    logic [DATA_W-1:0] ram [0:4095];

    int nAsserts = 0;
    int nFails   = 0;

    int          monCyc    = 0;
    int          busyCount = 0;
    int          monFalls  = 0;
    int          lastFall  = 0;
    int          lowStart  = 0;
    bit          inFrame   = 1'b0;
    logic        prevS     = 1'b1;
    logic        prevCs    = 1'b1;
    logic        prevD     = 1'b0;
    logic [15:0] curWord   = '0;
    int          frameStart[$];
    int          frameEnd[$];
    int          frameAddr[$];
    int          frameFalls[$];
    int          frameLow[$];
    int          doneCycles[$];
    logic [15:0] frameWord[$];

    always #5 ipDspClk = ~ipDspClk;

    dac_waveform_player #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLK_DIV(CD), .SAMPLE_PERIOD(SP)
    ) dut (
        .ipDspClk(ipDspClk), .Reset(Reset), .ipEnable(ipEnable), .ipLength(ipLength),
        .ipTrigger(ipTrigger), .opAddress(opAddress), .ipReadData(ipReadData),
        .opSClk(opSClk), .opnCS(opnCS), .opData(opData), .opBusy(opBusy),
        .opDone(opDone), .opMissedCount(opMissedCount)
    );

    always @(posedge ipDspClk) ipReadData <= ram[opAddress];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offset-binary DAC code of a signed sample, scaled into the top 14 of 16 bits
    function automatic logic [15:0] dacCode(input logic [13:0] s);
        int v;
        v = int'($signed(s));
        return 16'((v + 8192) * 4);
    endfunction

    always @(negedge ipDspClk) begin
        monCyc++;
        if (Reset) begin
            inFrame  = 1'b0;
            monFalls = 0;
        end else begin
            if (opnCS === 1'b1) begin
                chk("sclk_high_idle", 32'(opSClk), 1);
                chk("data_low_idle", 32'(opData), 0);
            end
            if (opnCS === 1'b0 && prevCs === 1'b1) begin
                inFrame  = 1'b1;
                curWord  = '0;
                monFalls = 0;
                lowStart = monCyc;
                frameStart.push_back(monCyc);
                frameAddr.push_back(int'(opAddress));
            end
            if (inFrame && prevS === 1'b1 && opSClk === 1'b0) begin
                chk("data_stable_fall", 32'(opData), 32'(prevD));
                if (monFalls > 0) chk("sclk_period", monCyc - lastFall, 2 * CD);
                curWord  = {curWord[14:0], opData};
                monFalls++;
                lastFall = monCyc;
            end
            if (inFrame && opnCS === 1'b1 && prevCs === 1'b0) begin
                frameWord.push_back(curWord);
                frameFalls.push_back(monFalls);
                frameLow.push_back(monCyc - lowStart);
                frameEnd.push_back(monCyc);
                inFrame = 1'b0;
            end
            if (opDone === 1'b1) doneCycles.push_back(monCyc);
            if (opBusy === 1'b1) busyCount++;
        end
        prevS  = opSClk;
        prevCs = opnCS;
        prevD  = opData;
    end

    task automatic clearRecords();
        frameStart.delete();
        frameEnd.delete();
        frameAddr.delete();
        frameFalls.delete();
        frameLow.delete();
        frameWord.delete();
        doneCycles.delete();
    endtask

    task automatic randomizeRam();
        for (int i = 0; i < 4096; i++) ram[i] = 14'($urandom);
    endtask

    task automatic pulseTrig();
        @(posedge ipDspClk);
        #1 ipTrigger = 1'b1;
        @(posedge ipDspClk);
        #1 ipTrigger = 1'b0;
    endtask

    task automatic waitDone(input bit trigInDone);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge ipDspClk);
            if (opDone === 1'b1) seen = 1'b1;
            n++;
        end
        chk("done_seen", 32'(seen), 1);
        chk("busy_in_done", 32'(opBusy), 1);
        if (trigInDone) ipTrigger = 1'b1;
        @(posedge ipDspClk);
        #1 ipTrigger = 1'b0;
        @(negedge ipDspClk);
        chk("busy_after_done", 32'(opBusy), 0);
        chk("done_one_cycle", 32'(opDone), 0);
    endtask

    task automatic checkBurst(input int nFrames);
        chk("frame_count", frameWord.size(), nFrames);
        for (int i = 0; i < frameWord.size() && i < nFrames; i++) begin
            chk("frame_addr", frameAddr[i], i);
            chk("frame_word", 32'(frameWord[i]), 32'(dacCode(ram[i])));
            chk("frame_bits", frameFalls[i], 16);
            chk("ncs_low_len", frameLow[i], 32 * CD);
            if (i > 0) chk("frame_spacing", frameStart[i] - frameStart[i-1], SP);
        end
        chk("done_count", doneCycles.size(), 1);
        if (doneCycles.size() > 0 && frameEnd.size() > 0)
            chk("done_after_last_frame",
                32'((doneCycles[0] > frameEnd[$]) && (doneCycles[0] <= frameEnd[$] + 2)), 1);
    endtask

    initial begin
        int n;
        Reset     = 1'b1;
        ipEnable  = 1'b0;
        ipTrigger = 1'b0;
        ipLength  = '0;
        randomizeRam();
        repeat (3) @(posedge ipDspClk);
        @(negedge ipDspClk);
        chk("rst_sclk", 32'(opSClk), 1);
        chk("rst_ncs", 32'(opnCS), 1);
        chk("rst_data", 32'(opData), 0);
        chk("rst_busy", 32'(opBusy), 0);
        chk("rst_done", 32'(opDone), 0);
        chk("rst_missed", 32'(opMissedCount), 0);
        chk("rst_addr", 32'(opAddress), 0);
        @(posedge ipDspClk);
        #1 Reset = 1'b0;
        ipEnable = 1'b1;

        // Three-sample burst with the mapping corner values
        clearRecords();
        ram[0] = 14'h0000;
        ram[1] = 14'h1FFF;
        ram[2] = 14'h2000;
        ipLength = 12'd3;
        pulseTrig();
        waitDone(1'b0);
        checkBurst(3);
        chk("word0_const", 32'(frameWord.size() > 0 ? frameWord[0] : 16'h0), 32'h8000);
        chk("missed_after_b1", 32'(opMissedCount), 0);

        // Triggers while busy, including the opDone cycle; length change must not re-latch
        clearRecords();
        randomizeRam();
        ipLength = 12'd4;
        pulseTrig();
        ipLength = 12'd9;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(5, 60)) @(posedge ipDspClk);
            pulseTrig();
        end
        waitDone(1'b1);
        checkBurst(4);
        chk("missed_four", 32'(opMissedCount), 4);

        // Ignored triggers: zero length, then disabled
        clearRecords();
        busyCount = 0;
        ipLength = 12'd0;
        pulseTrig();
        ipLength = 12'd5;
        ipEnable = 1'b0;
        pulseTrig();
        ipEnable = 1'b1;
        repeat (200) @(posedge ipDspClk);
        chk("noop_frames", frameStart.size(), 0);
        chk("noop_busy", busyCount, 0);
        chk("noop_missed", 32'(opMissedCount), 4);
        chk("noop_done", doneCycles.size(), 0);

        // Enable dropped inside frame 4 of a 10-sample burst
        clearRecords();
        randomizeRam();
        ipLength = 12'd10;
        pulseTrig();
        n = 0;
        while (!(frameStart.size() == 4 && monFalls >= 3) && n < 2000) begin
            @(negedge ipDspClk);
            n++;
        end
        chk("reach_frame4", 32'(n < 2000), 1);
        @(posedge ipDspClk);
        #1 ipEnable = 1'b0;
        waitDone(1'b0);
        checkBurst(4);
        ipEnable = 1'b1;

        // Trigger held for 300 cycles during a burst saturates the missed counter
        clearRecords();
        randomizeRam();
        ipLength = 12'd6;
        @(posedge ipDspClk);
        #1 ipTrigger = 1'b1;
        repeat (300) @(posedge ipDspClk);
        #1 ipTrigger = 1'b0;
        waitDone(1'b0);
        checkBurst(6);
        chk("missed_sat", 32'(opMissedCount), 255);

        // Reset in the middle of bit 7 of frame 2, then a fresh burst from address 0
        clearRecords();
        randomizeRam();
        ipLength = 12'd5;
        pulseTrig();
        n = 0;
        while (!(frameStart.size() == 2 && monFalls >= 7) && n < 2000) begin
            @(negedge ipDspClk);
            n++;
        end
        chk("reach_bit7", 32'(n < 2000), 1);
        @(posedge ipDspClk);
        #1 Reset = 1'b1;
        @(posedge ipDspClk);
        @(negedge ipDspClk);
        chk("mid_rst_ncs", 32'(opnCS), 1);
        chk("mid_rst_sclk", 32'(opSClk), 1);
        chk("mid_rst_data", 32'(opData), 0);
        chk("mid_rst_busy", 32'(opBusy), 0);
        chk("mid_rst_missed", 32'(opMissedCount), 0);
        chk("mid_rst_addr", 32'(opAddress), 0);
        @(posedge ipDspClk);
        #1 Reset = 1'b0;
        clearRecords();
        randomizeRam();
        ipLength = 12'd2;
        pulseTrig();
        waitDone(1'b0);
        checkBurst(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
